// File: rtl/mon_exp_win_if.sv
// Handshake bundle between the host/RSA control, the exponentiation sequencer and mon_prod.
// The master modport is the sequencer view; slave is the host + mon_prod side.
interface mon_exp_win_if #(
   parameter int BITLEN     = 256,
   parameter int LOG_BITLEN = 8,
   parameter int WIN        = 2
);
   logic                  start;
   logic [BITLEN-1:0]     e;
   logic [LOG_BITLEN-1:0] e_msb;
   logic                  busy;
   logic                  done;
   logic                  mp_start;
   logic [2:0]            mp_op;
   logic [WIN-1:0]        mp_idx;
   logic                  mp_done;

   modport master (
      input  start, e, e_msb, mp_done,
      output busy, done, mp_start, mp_op, mp_idx
   );

   modport slave (
      output start, e, e_msb, mp_done,
      input  busy, done, mp_start, mp_op, mp_idx
   );
endinterface

// File: rtl/mon_exp_win.sv
// Fixed-window k-ary Montgomery exponentiation sequencer: builds the power table, then
// scans e window by window and drives one mon_prod operation at a time.
module mon_exp_win #(
   parameter int BITLEN     = 256,
   parameter int LOG_BITLEN = 8,
   parameter int WIN        = 2
) (
   input  logic            clk,
   input  logic            rst,
   mon_exp_win_if.master   bus
);
   localparam logic [2:0] OP_SQR = 3'd0;
   localparam logic [2:0] OP_MUL = 3'd1;
   localparam logic [2:0] OP_TBL = 3'd2;
   localparam logic [2:0] OP_X1  = 3'd3;
   localparam logic [2:0] OP_LD1 = 3'd4;

   localparam logic [WIN-1:0]        IDX_MAX   = {WIN{1'b1}};
   localparam logic [WIN-1:0]        IDX_FIRST = WIN'(2);
   localparam logic [2:0]            SQ_INIT   = 3'(WIN);
   localparam logic [LOG_BITLEN-1:0] WIN_L     = LOG_BITLEN'(WIN);
   localparam logic [LOG_BITLEN:0]   EMSB_MAX  = (LOG_BITLEN+1)'(BITLEN-1);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_PRE    = 4'd1,
      S_PRE_W  = 4'd2,
      S_LOAD   = 4'd3,
      S_LOAD_W = 4'd4,
      S_SQR    = 4'd5,
      S_SQR_W  = 4'd6,
      S_MUL    = 4'd7,
      S_MUL_W  = 4'd8,
      S_NEXT   = 4'd9,
      S_CONV   = 4'd10,
      S_CONV_W = 4'd11,
      S_FIN    = 4'd12
   } state_t;

   state_t                r_state;
   logic [BITLEN-1:0]     r_e;
   logic [LOG_BITLEN-1:0] r_emsb;
   logic [LOG_BITLEN-1:0] r_j;
   logic [2:0]            r_sq;
   logic [WIN-1:0]        r_tidx;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_mp_start;
   logic [2:0]            r_mp_op;
   logic [WIN-1:0]        r_mp_idx;

   state_t                w_state_nxt;
   logic [BITLEN-1:0]     w_e_nxt;
   logic [LOG_BITLEN-1:0] w_emsb_nxt;
   logic [LOG_BITLEN-1:0] w_j_nxt;
   logic [2:0]            w_sq_nxt;
   logic [WIN-1:0]        w_tidx_nxt;
   logic                  w_busy_nxt;
   logic                  w_done_nxt;
   logic                  w_mp_start_nxt;
   logic [2:0]            w_mp_op_nxt;
   logic [WIN-1:0]        w_mp_idx_nxt;

   logic [LOG_BITLEN-1:0] w_emsb_c;
   logic [BITLEN-1:0]     w_emask;
   logic [LOG_BITLEN-1:0] w_top_j;
   logic [LOG_BITLEN-1:0] w_shift;
   logic [WIN-1:0]        w_win;

   // Clamp e_msb, build the keep-mask for bits at or below it, and extract window j.
   always_comb begin
      if ({1'b0, bus.e_msb} > EMSB_MAX) begin
         w_emsb_c = EMSB_MAX[LOG_BITLEN-1:0];
      end else begin
         w_emsb_c = bus.e_msb;
      end
      w_emask = ~(({BITLEN{1'b1}} << w_emsb_c) << 1'b1);
      w_top_j = r_emsb / WIN_L;
      w_shift = r_j * WIN_L;
      w_win   = WIN'(r_e >> w_shift);
   end

   // Next-state and sequencing counters.
   always_comb begin
      w_state_nxt = r_state;
      w_e_nxt     = r_e;
      w_emsb_nxt  = r_emsb;
      w_j_nxt     = r_j;
      w_sq_nxt    = r_sq;
      w_tidx_nxt  = r_tidx;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               // Masking here makes the top window zero-padded and ignores bits above e_msb.
               w_e_nxt    = bus.e & w_emask;
               w_emsb_nxt = w_emsb_c;
               w_tidx_nxt = IDX_FIRST;
               if (WIN > 1) begin
                  w_state_nxt = S_PRE;
               end else begin
                  w_state_nxt = S_LOAD;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_PRE:    w_state_nxt = S_PRE_W;
         S_PRE_W: begin
            if (bus.mp_done) begin
               if (r_tidx == IDX_MAX) begin
                  w_state_nxt = S_LOAD;
               end else begin
                  w_tidx_nxt  = r_tidx + WIN'(1);
                  w_state_nxt = S_PRE;
               end
            end else begin
               w_state_nxt = S_PRE_W;
            end
         end
         S_LOAD:   w_state_nxt = S_LOAD_W;
         S_LOAD_W: begin
            if (bus.mp_done) begin
               w_j_nxt     = w_top_j;
               w_sq_nxt    = SQ_INIT;
               w_state_nxt = S_SQR;
            end else begin
               w_state_nxt = S_LOAD_W;
            end
         end
         S_SQR: begin
            w_sq_nxt    = r_sq - 3'd1;
            w_state_nxt = S_SQR_W;
         end
         S_SQR_W: begin
            if (bus.mp_done) begin
               if (r_sq != 3'd0) begin
                  w_state_nxt = S_SQR;
               end else if (w_win != {WIN{1'b0}}) begin
                  w_state_nxt = S_MUL;
               end else begin
                  w_state_nxt = S_NEXT;
               end
            end else begin
               w_state_nxt = S_SQR_W;
            end
         end
         S_MUL:    w_state_nxt = S_MUL_W;
         S_MUL_W: begin
            if (bus.mp_done) begin
               w_state_nxt = S_NEXT;
            end else begin
               w_state_nxt = S_MUL_W;
            end
         end
         S_NEXT: begin
            if (r_j == {LOG_BITLEN{1'b0}}) begin
               w_state_nxt = S_CONV;
            end else begin
               w_j_nxt     = r_j - LOG_BITLEN'(1);
               w_sq_nxt    = SQ_INIT;
               w_state_nxt = S_SQR;
            end
         end
         S_CONV:   w_state_nxt = S_CONV_W;
         S_CONV_W: begin
            if (bus.mp_done) begin
               w_state_nxt = S_FIN;
            end else begin
               w_state_nxt = S_CONV_W;
            end
         end
         S_FIN:    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so every output leaves a flop; op/idx hold through the wait.
   always_comb begin
      w_mp_start_nxt = 1'b0;
      w_mp_op_nxt    = r_mp_op;
      w_mp_idx_nxt   = r_mp_idx;
      case (w_state_nxt)
         S_PRE: begin
            w_mp_start_nxt = 1'b1;
            w_mp_op_nxt    = OP_TBL;
            w_mp_idx_nxt   = w_tidx_nxt;
         end
         S_LOAD: begin
            w_mp_start_nxt = 1'b1;
            w_mp_op_nxt    = OP_LD1;
            w_mp_idx_nxt   = {WIN{1'b0}};
         end
         S_SQR: begin
            w_mp_start_nxt = 1'b1;
            w_mp_op_nxt    = OP_SQR;
            w_mp_idx_nxt   = {WIN{1'b0}};
         end
         S_MUL: begin
            w_mp_start_nxt = 1'b1;
            w_mp_op_nxt    = OP_MUL;
            w_mp_idx_nxt   = w_win;
         end
         S_CONV: begin
            w_mp_start_nxt = 1'b1;
            w_mp_op_nxt    = OP_X1;
            w_mp_idx_nxt   = {WIN{1'b0}};
         end
         default: begin
            w_mp_start_nxt = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
      w_done_nxt = (w_state_nxt == S_FIN);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_e        <= {BITLEN{1'b0}};
         r_emsb     <= {LOG_BITLEN{1'b0}};
         r_j        <= {LOG_BITLEN{1'b0}};
         r_sq       <= 3'd0;
         r_tidx     <= {WIN{1'b0}};
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mp_start <= 1'b0;
         r_mp_op    <= 3'd0;
         r_mp_idx   <= {WIN{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_e        <= w_e_nxt;
         r_emsb     <= w_emsb_nxt;
         r_j        <= w_j_nxt;
         r_sq       <= w_sq_nxt;
         r_tidx     <= w_tidx_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_mp_start <= w_mp_start_nxt;
         r_mp_op    <= w_mp_op_nxt;
         r_mp_idx   <= w_mp_idx_nxt;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.mp_start = r_mp_start;
   assign bus.mp_op    = r_mp_op;
   assign bus.mp_idx   = r_mp_idx;
endmodule
